// File: rtl/sw_ctrl.sv
// Stopwatch control: debounced start/stop and lap/reset buttons drive a
// four-state FSM that emits a count-enable tick, a counter clear and a display hold.

module sw_deb #(
  parameter int DEB_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          s1_q, s2_q, lvl_q, lvl_d, press_q, press_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == DW'(DEB_CYC - 1)) begin
      lvl_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module sw_ctrl #(
  parameter int DEB_CYC = 250000,
  parameter int DIV     = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic       tick,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);
  localparam int NUM_BTN = 2;
  localparam int PW      = $clog2(DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, PAUSE = 2'd3} st_e;

  logic [NUM_BTN-1:0] btn_raw, press;
  assign btn_raw = {btn_lap, btn_ss};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    sw_deb #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  logic ss, lap;
  assign ss  = press[0];
  assign lap = press[1];

  st_e           state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d, clr_q, clr_d, hold_q, hold_d, run_q, run_d;
  logic          active;

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    // ss has priority; a simultaneous lap press is dropped.
    case (state_q)
      IDLE:  if (ss) state_d = RUN;   else if (lap) clr_d = 1'b1;
      RUN:   if (ss) state_d = PAUSE; else if (lap) state_d = LAP;
      LAP:   if (ss) state_d = PAUSE; else if (lap) state_d = RUN;
      PAUSE: if (ss) state_d = RUN;
             else if (lap) begin state_d = IDLE; clr_d = 1'b1; end
    endcase
    run_d  = (state_d == RUN) || (state_d == LAP);
    hold_d = (state_d == LAP);
    // Count only across edges that stay in RUN/LAP; entry/exit edges hold the phase.
    active = run_q && run_d;
    tick_d = active && (pre_q == PW'(DIV - 1));
    pre_d  = pre_q;
    if (state_d == IDLE || clr_d)  pre_d = '0;
    else if (tick_d)               pre_d = '0;
    else if (active)               pre_d = pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
    end
  end

  assign tick      = tick_q;
  assign cnt_clr   = clr_q;
  assign disp_hold = hold_q;
  assign running   = run_q;
  assign state     = state_q;
endmodule

// File: tb/tb_sw_ctrl.sv
// Randomized button stimulus against an event-level stopwatch model; a per-cycle
// scoreboard compares the DUT outputs with the model's expected vector.

module tb_sw_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 5;

  logic       clk, rst, btn_ss, btn_lap;
  logic       tick, cnt_clr, disp_hold, running;
  logic [1:0] state;

  sw_ctrl #(.DEB_CYC(DEB), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .tick(tick), .cnt_clr(cnt_clr), .disp_hold(disp_hold),
    .running(running), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // expected vector: {state[1:0], running, disp_hold, tick, cnt_clr}
  logic [5:0] exp_q[$];

  // Model state: stopwatch mode, run-cycle count, per-button sync pipe and history.
  int m_state, m_runcyc;
  bit m_s1[2], m_s2[2], m_lvl[2], m_press[2];
  bit m_hist0[$], m_hist1[$];

  function automatic bit flips(input bit h[$], input bit lvl);
    if (h.size() < DEB) return 1'b0;
    foreach (h[i]) if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_state = 0; m_runcyc = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0;
      end
      m_hist0.delete(); m_hist1.delete();
      exp_q.push_back(6'b0);
    end else begin
      int  nxt;
      bit  clr, tk, prun, nrun;
      nxt = m_state; clr = 0; tk = 0;
      prun = (m_state == 1 || m_state == 2);
      if (m_press[0]) nxt = (m_state == 0 || m_state == 3) ? 1 : 3;
      else if (m_press[1]) begin
        case (m_state)
          0: clr = 1;
          1: nxt = 2;
          2: nxt = 1;
          default: begin nxt = 0; clr = 1; end
        endcase
      end
      nrun = (nxt == 1 || nxt == 2);
      if (nxt == 0) m_runcyc = 0;
      else if (prun && nrun) begin
        m_runcyc++;
        tk = (m_runcyc % DIV) == 0;
      end
      exp_q.push_back({2'(nxt), nrun, nxt == 2, tk, clr});
      m_state = nxt;
      // debounce: level follows after DEB consecutive disagreeing samples
      m_hist0.push_back(m_s2[0]); if (m_hist0.size() > DEB) void'(m_hist0.pop_front());
      m_hist1.push_back(m_s2[1]); if (m_hist1.size() > DEB) void'(m_hist1.pop_front());
      m_press[0] = 0; m_press[1] = 0;
      if (flips(m_hist0, m_lvl[0])) begin m_lvl[0] = m_s2[0]; m_press[0] = m_lvl[0]; end
      if (flips(m_hist1, m_lvl[1])) begin m_lvl[1] = m_s2[1]; m_press[1] = m_lvl[1]; end
      m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
      m_s1[0] = btn_ss;  m_s1[1] = btn_lap;
    end
  end

  always @(negedge clk) begin
    logic [5:0] got, e;
    got = {state, running, disp_hold, tick, cnt_clr};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL outputs t=%0t: no expected entry, got %b", $time, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got {st,run,hold,tick,clr}=%b expected %b", $time, got, e);
      end
    end
  end

  task automatic pulse(input bit ss, input bit lp, input int hi, input int lo);
    @(negedge clk); btn_ss = ss; btn_lap = lp;
    repeat (hi) @(negedge clk);
    btn_ss = 0; btn_lap = 0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    rst = 0; btn_ss = 0; btn_lap = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (100) @(negedge clk);
    pulse(1, 0, 3, 12);          // glitch, ignored
    pulse(1, 0, 10, 30);         // IDLE -> RUN
    pulse(0, 1, 6, 25);          // LAP
    pulse(0, 1, 6, 25);          // back to RUN
    pulse(1, 0, 6, 13);          // PAUSE
    pulse(1, 0, 6, 20);          // resume
    pulse(1, 0, 6, 15);          // PAUSE
    pulse(0, 1, 6, 15);          // IDLE with clear
    pulse(0, 1, 6, 15);          // clear in IDLE
    pulse(1, 0, 6, 15);          // RUN
    pulse(1, 1, 6, 20);          // both: PAUSE wins
    repeat (300) begin
      int sel, hi, lo;
      sel = $urandom_range(0, 3);
      hi  = $urandom_range(1, 9);
      lo  = $urandom_range(1, 14);
      pulse(sel[0], sel[1], hi, lo);
    end
    // clean restart, then reset asynchronously while in LAP
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    pulse(1, 0, 6, 10);
    pulse(0, 1, 6, 10);
    for (int i = 0; i < 50 && m_state != 2; i++) @(negedge clk);
    checks++;
    if (m_state != 2) begin
      errors++;
      $display("FAIL reach_lap: model state %0d, required 2", m_state);
    end
    @(negedge clk); #2 rst = 0;
    #1;
    checks++;
    if ({state, running, disp_hold, tick, cnt_clr} !== 6'b0) begin
      errors++;
      $display("FAIL async_rst: got %b required 000000",
               {state, running, disp_hold, tick, cnt_clr});
    end
    @(negedge clk); rst = 1;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sw_ctrl.md
Name: sw_ctrl

Overview:
- Control FSM that sequences the stopwatch counter chain from two raw push-buttons: start/stop and lap/reset.
- Debounces and edge-detects both buttons.
- Generates a single-cycle count-enable tick from the system clock, a synchronous clear for the counters, and a display-hold (lap freeze) flag.
- Replaces gated-clock counting: all downstream counters run on clk and use tick as an enable.

Parameters:
- DEB_CYC, 250000: consecutive stable cycles required before a debounced level changes (5 ms at 50 MHz).
- DIV, 500000: clk cycles per tick (10 ms at 50 MHz); must be >= 2.

Ports:
- clk  input  1  system clock; every flop is on its rising edge.
- rst  input  1  asynchronous active-low reset.
- btn_ss  input  1  raw start/stop button, asynchronous, active-high.
- btn_lap  input  1  raw lap/reset button, asynchronous, active-high.
- tick  output  1  one-cycle count-enable pulse, 1 per DIV cycles while counting.
- cnt_clr  output  1  one-cycle synchronous clear to all counters.
- disp_hold  output  1  high = display registers freeze (lap view).
- running  output  1  high in RUN or LAP.
- state  output  2  current FSM state encoding.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE(2'd0); tick, cnt_clr, disp_hold and running all 0.
  - Synchronizers, debounce counters, debounced levels and prescaler all cleared.
- Input conditioning, per button, independent:
  - 2-flop synchronizer.
  - Debounce counter resets to 0 whenever the synchronized value equals the debounced level; otherwise it increments.
  - When the counter reaches DEB_CYC-1, the debounced level takes the synchronized value and the counter resets.
  - Press pulse (1 cycle) on the debounced 0->1 transition; release produces nothing.
  - Raw edge to debounced change: 2+DEB_CYC cycles. Glitches shorter than DEB_CYC cycles are ignored.
- FSM states: IDLE=0, RUN=1, LAP=2, PAUSE=3. The transition is taken on the clk edge after the press pulse.
  - IDLE:
    - ss -> RUN.
    - lap -> stay IDLE, cnt_clr=1 for one cycle.
  - RUN:
    - ss -> PAUSE.
    - lap -> LAP.
  - LAP (counting continues, display frozen):
    - ss -> PAUSE.
    - lap -> RUN, which releases the hold so the display jumps to the live time.
  - PAUSE:
    - ss -> RUN.
    - lap -> IDLE, with cnt_clr=1 for one cycle, registered together with the state change.
  - Simultaneous ss and lap pulses in the same cycle: ss wins, lap is discarded.
- Outputs are registered and decoded from the next state, so they are valid in the same cycle the state is valid.
  - running=1 in RUN and LAP.
  - disp_hold=1 only in LAP.
- Prescaler, ceil(log2(DIV)) bits:
  - Increments only while running.
  - Holds its value in PAUSE, so the fractional tick is preserved across pause/resume.
  - Forced to 0 in IDLE and on the cnt_clr cycle.
  - At DIV-1: tick=1 that cycle and the count wraps to 0. tick is never high outside RUN/LAP.
- First tick after IDLE->RUN: exactly DIV cycles after state becomes RUN.
- tick and cnt_clr are never both 1. cnt_clr only occurs in IDLE or on the PAUSE->IDLE edge.
- Reset mid-operation: immediate return to IDLE with all outputs 0; cnt_clr is not generated (the counters have their own reset).

Test Plan (DEB_CYC=4, DIV=5):
- Reset release, no buttons:
  - state=0 and all outputs 0 for 100 cycles.
  - Glitch btn_ss high 3 cycles: no state change.
- Press btn_ss 10 cycles:
  - state=1 and running=1 exactly 7 cycles after the raw rise (2 sync + 4 debounce + 1).
  - tick pulses every 5 cycles, first one 5 cycles after entry.
  - Button release causes no transition.
- RUN, press btn_lap:
  - state=2, disp_hold=1, tick continues every 5 cycles.
  - Press btn_lap again: state=1, disp_hold=0.
- RUN, press btn_ss when the prescaler is at 2:
  - state=3 and tick stops.
  - Press btn_ss again: state=1, next tick arrives 3 cycles after resume (prescaler held).
- PAUSE, press btn_lap:
  - state=0 and cnt_clr=1 for exactly one cycle.
  - Prescaler reads 0; tick stays low.
- Both buttons rising in the same cycle from RUN: state=3 (ss priority), no LAP and no cnt_clr.
- Assert rst=0 mid-LAP: outputs drop to 0 asynchronously before the next clk edge; state=0.
